uart_tx_buffered: RTL
=====================

Name: uart_tx_buffered

Overview:
- UART transmit path for the smart-watch top: buffers bytes from internal producers (command echo, distance and temperature reports) in a FIFO and serializes them on `tx`.
- Frame format is 8N1, LSB first, 9600 bps at 100 MHz.
- Counterpart of the existing UART receive + FIFO path that decodes host commands ("M", "T", "R", ...).
- Producers push a byte and never wait on the line.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (10416 at defaults).
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes (16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write strobe; one byte per cycle.
- push_data  in  8  byte to enqueue.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  DEPTH_LOG2+1  bytes currently in FIFO (excludes byte in shifter).
- overflow  out  1  one-cycle pulse when push is rejected.
- tx_busy  out  1  high while a frame is on the line.
- tx  out  1  serial output, idle high.

Behaviour:
- Reset values, taking effect on the edge with rst=1: tx=1, tx_busy=0, full=0, empty=1, count=0, overflow=0, FSM=IDLE, pointers=0, bit counter=0, baud counter=0.
- Reset mid-frame aborts the frame: tx returns high at that edge, and FIFO contents are discarded.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap modulo DEPTH.
  - full, empty and count are registered and derived from count.
  - Push accepted iff push=1 and full=0 (registered value). Data is written at that edge, wptr+1, count+1.
  - Push while full: data dropped, FIFO unchanged, overflow=1 for exactly the next cycle.
  - This holds even if a pop happens in the same cycle.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Push to an empty FIFO while the FSM is idle: the byte is not forwarded directly; it goes through the FIFO.
- FSM states: IDLE, START, DATA, STOP. tx is registered.
  - IDLE: tx=1, tx_busy=0. If empty=0, then at that edge pop one byte into an 8-bit shifter, rptr+1, count-1, go to START, tx<=0, tx_busy<=1, baud counter<=0.
  - START: hold tx=0 for CLKS_PER_BIT clocks. Then tx<=shifter[0], bit index<=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT clocks, LSB first. After bit 7 completes, tx<=1, go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT clocks. At the end, if empty=0, pop and go directly to START (tx<=0, no idle gap). Otherwise go to IDLE and set tx_busy<=0.
- Timing:
  - Latency: push accepted at edge k into an idle, empty block → tx falls at edge k+1.
  - Frame length is exactly 10*CLKS_PER_BIT clocks.
  - Back-to-back frames are separated only by the stop bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state or bit transition. No fractional-rate correction.
- A push during transmission never disturbs the current frame.

Decomposition:
- Shared include (uart_defs): CLK_FREQ, BAUD, CLKS_PER_BIT, the frame state encodings IDLE/START/DATA/STOP, and the ASCII command constants, shared with the receive path.
- One sub-module, `uart_tx_fifo`: parameterized synchronous FIFO (push/pop/full/empty/count/overflow).
- Top level is the FSM, shifter and baud counter.

Test Plan (sim with CLK_FREQ=1000, BAUD=100 → CLKS_PER_BIT=10):
- Single byte: push 0x4D ("M") at edge k → tx low from k+1 for 10 clocks. Data bits 1,0,1,1,0,0,1,0 (LSB first), 10 clocks each. Then tx high. tx_busy falls at k+101.
- Burst: push 0x4D, 0x54, 0x52 on consecutive cycles → count peaks at 2. Three frames are contiguous (300 clocks), no idle between stop and next start. The bench UART-decodes "M","T","R" in order.
- Overflow: with the FSM held mid-frame, push 17 bytes (0x00..0x10) → full=1 after the 16th accepted push. The 17th push gives a one-cycle overflow pulse and count stays 16. Output sequence is 0x00..0x0F, and 0x10 is never sent.
- Wrap-around: push and drain 40 bytes in groups of 5 → pointers wrap twice. Every byte is received in order, and empty=1 at the end.
- Reset mid-frame: assert rst during DATA bit 3 of 0xA5 with 3 bytes queued → tx=1, count=0, empty=1 at the edge after rst. After release there is no further frame until a new push.
- Push during STOP: push 0x44 while the last frame's stop bit is at clock 5 → the next START follows the stop bit with no gap, and 0x44 is decoded.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Holds the default line timing, the serializer frame states and the ASCII
// host command bytes that both directions use.
package uart_tx_buffered_pkg;

  localparam int unsigned DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned DEF_BAUD     = 9600;

  // Frame phases of the serializer
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Host command bytes ("M", "T", "R")
  localparam logic [7:0] CMD_MEASURE = 8'h4D;
  localparam logic [7:0] CMD_TEMP    = 8'h54;
  localparam logic [7:0] CMD_RESET   = 8'h52;

  // Integer clocks per bit; no fractional-rate correction
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous byte FIFO in front of the UART serializer.
// Ports:
//   clk, rst        clock, synchronous active-high reset (discards contents)
//   push, push_data write strobe and byte; ignored while full
//   pop, pop_data   read strobe and head byte (combinational head)
//   full, empty     registered, derived from the next occupancy
//   count           registered occupancy 0..DEPTH
//   overflow        one-cycle pulse after a rejected push
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  do_push;
  logic                  do_pop;
  logic [DEPTH_LOG2:0]   count_nxt;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count    <= count_nxt;
      full     <= (count_nxt == (DEPTH_LOG2+1)'(DEPTH));
      empty    <= (count_nxt == '0);
      // A push against a full FIFO is dropped even if a pop frees a slot now
      overflow <= push && full;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: 8N1, LSB first, FIFO-fed serializer.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts any frame)
//   push       enqueue push_data (one byte per cycle)
//   push_data  byte to enqueue
//   full/empty/count/overflow  FIFO status (count excludes the shifter byte)
//   tx_busy    high while a frame is on the line
//   tx         registered serial output, idle high
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [7:0]          push_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                tx_busy,
  output logic                tx
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shifter, shifter_nxt;
  logic              tx_nxt, busy_nxt;
  logic              fifo_pop;
  logic [7:0]        fifo_data;
  logic              bit_end;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_idx_nxt;
      shifter  <= shifter_nxt;
      tx       <= tx_nxt;
      tx_busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (bit_end) state_nxt = empty ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered line, busy flag and datapath
  always_comb begin
    fifo_pop    = 1'b0;
    baud_nxt    = baud_cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shifter_nxt = shifter;
    tx_nxt      = tx;
    busy_nxt    = tx_busy;
    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (!empty) begin
          fifo_pop    = 1'b1;
          shifter_nxt = fifo_data;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          tx_nxt      = shifter[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt = 1'b1;
          end else begin
            // Shift so the next bit to send is always at position 0/1
            bit_idx_nxt = bit_idx + 3'd1;
            shifter_nxt = shifter >> 1;
            tx_nxt      = shifter[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (!empty) begin
            // Chain straight into the next start bit, no idle gap
            fifo_pop    = 1'b1;
            shifter_nxt = fifo_data;
            tx_nxt      = 1'b0;
          end else begin
            tx_nxt   = 1'b1;
            busy_nxt = 1'b0;
          end
        end
      end
      default: begin
        baud_nxt = '0;
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule
